send_data: RTL
==============

SEND_DATA -- requirements
Module: send_data

Interface
REQ-001 SHALL have parameter SUM_W, default 16, width of the sum value; legal values are 9..16.
REQ-002 SHALL have parameter HEADER, default 8'hA5, the first byte of every frame.
REQ-003 SHALL have port clk, input, 1, the single clock.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port en_send, input, 1, one-cycle pulse from the controller that arms streaming.
REQ-006 SHALL have port sum_ready, input, 1, one-cycle strobe marking sum as valid.
REQ-007 SHALL have port sum, input, SUM_W, the measured value.
REQ-008 SHALL have port thr_high and thr_low, inputs, 16 each, calibrated thresholds (alarm build only; see REQ-027).
REQ-009 SHALL have port tx_busy, input, 1, UART TX busy.
REQ-010 SHALL have port tx_start, output, 1, one-cycle request to the UART TX.
REQ-011 SHALL have port tx_data, output, 8, byte to transmit.
REQ-012 SHALL have port overrun, output, 1, one-cycle pulse when the pending sum is overwritten.
REQ-013 SHALL have port frame_cnt, output, 8, completed-frame counter.

Function
REQ-014 SHALL clear the armed flag on reset and set it on en_send; en_send while armed SHALL be ignored, and streaming SHALL then continue until reset.
REQ-015 SHALL use these states: IDLE (disarmed), WAIT_SUM, SEND, WAIT_HI, WAIT_LO.
REQ-016 SHALL move from IDLE to WAIT_SUM on en_send; sum_ready while disarmed SHALL be ignored.
REQ-017 SHALL, in WAIT_SUM with sum_ready=1, latch sum zero-extended to 16 bits into the frame register, clear byte_idx, and go to SEND.
REQ-018 SHALL form each frame as: HEADER, sum[15:8], sum[7:0], with a fourth status byte in the alarm build only.
REQ-019 SHALL, in SEND with tx_busy=0, register tx_start=1 and tx_data=frame byte[byte_idx] for exactly one cycle, then go to WAIT_HI; in SEND with tx_busy=1, stay in SEND.
REQ-020 SHALL, in WAIT_HI, go to WAIT_LO when tx_busy=1; the UART raises tx_busy no later than the cycle after tx_start.
REQ-021 SHALL, in WAIT_LO with tx_busy=0, increment byte_idx and return to SEND if bytes remain; otherwise it SHALL increment frame_cnt (8-bit, wrapping 255 to 0) and go to WAIT_SUM.
REQ-022 SHALL capture a sum_ready that arrives outside WAIT_SUM into a one-deep pending register and set pending_valid.
REQ-023 SHALL, when sum_ready arrives while pending_valid=1, overwrite the pending value and pulse overrun for one cycle.
REQ-024 SHALL, on frame completion with pending_valid=1, load the pending value, clear pending_valid, and go straight to SEND.
REQ-025 SHALL, when sum_ready and frame completion coincide, load the new sum directly into the frame register, raise no overrun, and pulse overrun only if pending_valid was already 1 (the new sum wins and the old pending value is discarded).

Reset
REQ-026 SHALL, on reset (even mid-frame), asynchronously force state=IDLE, armed=0, tx_start=0, tx_data=8'h00, overrun=0, frame_cnt=0, pending_valid=0 and byte_idx=0; a partial frame SHALL be abandoned and not resumed.

Configuration
REQ-027 SHALL, with SEND_DATA_ALARM_EN defined, append status byte {6'b0, sum>thr_high, sum<thr_low}, with thresholds sampled when the frame is latched, giving a 4-byte frame.
REQ-028 SHALL, without SEND_DATA_ALARM_EN, send 3-byte frames; thr_high and thr_low SHALL be left unused and no comparators SHALL be built.

Structure
REQ-029 SHALL take state encodings, HEADER default, and frame-length constants (3/4) from the shared package uart_pkg.
REQ-030 SHALL implement the frame register and byte mux in sub-module frame_builder (latch, byte select, optional status byte); the FSM, pending buffer and counters SHALL stay in send_data.

Verification
REQ-031 SHALL cover: en_send, then sum_ready with sum=16'h1234, UART with 1-cycle busy rise and 10-cycle busy -> tx_data sequence A5,12,34; frame_cnt=1.
REQ-032 SHALL cover: sum_ready with sum=16'h0001 before any en_send -> no tx_start, frame_cnt=0.
REQ-033 SHALL cover: during frame 1 (sum=16'h0010), sum_ready with 16'h0020 then 16'h0030 -> one overrun pulse; next frame carries 00,30 with no idle gap.
REQ-034 SHALL cover: reset asserted while in WAIT_LO of byte 2 -> tx_start=0 immediately; after release, no bytes until a new en_send.
REQ-035 SHALL cover: alarm build with thr_high=16'h0100, thr_low=16'h0050, sum=16'h0200 -> status byte 8'h02; sum=16'h0040 -> 8'h01.
REQ-036 SHALL cover: 256 frames -> frame_cnt wraps to 0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared constants for the send_data UART framer: FSM encoding, header, frame lengths.
// SEND_DATA_ALARM_EN selects the 4-byte frame carrying a threshold status byte.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT_SUM = 3'd1,
        ST_SEND     = 3'd2,
        ST_WAIT_HI  = 3'd3,
        ST_WAIT_LO  = 3'd4
    } tx_state_e;

    localparam logic [7:0] HEADER_DEFAULT  = 8'hA5;
    localparam int         FRAME_LEN_BASE  = 3;
    localparam int         FRAME_LEN_ALARM = 4;

`ifdef SEND_DATA_ALARM_EN
    localparam int FRAME_LEN = FRAME_LEN_ALARM;
`else
    localparam int FRAME_LEN = FRAME_LEN_BASE;
`endif

    localparam logic [1:0] LAST_IDX = 2'(FRAME_LEN - 1);

    function automatic logic [1:0] alarm_bits(input logic [15:0] value,
                                              input logic [15:0] thr_high,
                                              input logic [15:0] thr_low);
        return {(value > thr_high), (value < thr_low)};
    endfunction

endpackage

// File: rtl/send_data_frame_builder.sv
// Frame register and byte selector for send_data; the status byte exists only
// when SEND_DATA_ALARM_EN is defined.
module frame_builder
    import uart_pkg::*;
#(
    parameter logic [7:0] HEADER = HEADER_DEFAULT
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic        i_load,
    input  logic [15:0] i_value,
`ifdef SEND_DATA_ALARM_EN
    input  logic [15:0] i_thr_high,
    input  logic [15:0] i_thr_low,
`endif
    input  logic [1:0]  i_byte_idx,
    output logic [7:0]  o_byte
);

    logic [15:0] r_value;
`ifdef SEND_DATA_ALARM_EN
    logic [1:0]  r_status;

    // Thresholds are judged at latch time so a frame stays self-consistent.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_status <= 2'b00;
        end else if (i_load) begin
            r_status <= alarm_bits(i_value, i_thr_high, i_thr_low);
        end
    end
`endif

    // Frame value register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_value <= 16'h0000;
        end else if (i_load) begin
            r_value <= i_value;
        end
    end

    // Byte selector.
    always_comb begin
        o_byte = 8'h00;
        case (i_byte_idx)
            2'd0:    o_byte = HEADER;
            2'd1:    o_byte = r_value[15:8];
            2'd2:    o_byte = r_value[7:0];
`ifdef SEND_DATA_ALARM_EN
            2'd3:    o_byte = {6'b000000, r_status};
`endif
            default: o_byte = 8'h00;
        endcase
    end

endmodule

// File: rtl/send_data.sv
// Streams HEADER/sum frames to a UART TX once armed by en_send, with a one-deep
// pending buffer for sums arriving mid-frame. SEND_DATA_ALARM_EN adds a status byte.
module send_data
    import uart_pkg::*;
#(
    parameter int         SUM_W  = 16,
    parameter logic [7:0] HEADER = HEADER_DEFAULT
)
(
    input  logic             clk,
    input  logic             reset,
    input  logic             en_send,
    input  logic             sum_ready,
    input  logic [SUM_W-1:0] sum,
    input  logic [15:0]      thr_high,
    input  logic [15:0]      thr_low,
    input  logic             tx_busy,
    output logic             tx_start,
    output logic [7:0]       tx_data,
    output logic             overrun,
    output logic [7:0]       frame_cnt
);

    tx_state_e   r_state;
    logic        r_armed;
    logic [1:0]  r_byte_idx;
    logic [15:0] r_pend;
    logic        r_pend_valid;
    logic        r_tx_start;
    logic [7:0]  r_tx_data;
    logic        r_overrun;
    logic [7:0]  r_frame_cnt;

    logic [15:0] w_sum16;
    logic        w_frame_done;
    logic        w_load;
    logic [15:0] w_load_val;
    logic [7:0]  w_frame_byte;

    assign w_sum16      = 16'(sum);
    assign w_frame_done = (r_state == ST_WAIT_LO) && !tx_busy && (r_byte_idx == LAST_IDX);

    // Frame-register load: a fresh sum beats the pending value at frame end.
    always_comb begin
        w_load     = 1'b0;
        w_load_val = w_sum16;
        if ((r_state == ST_WAIT_SUM) && sum_ready) begin
            w_load = 1'b1;
        end else if (w_frame_done && sum_ready) begin
            w_load = 1'b1;
        end else if (w_frame_done && r_pend_valid) begin
            w_load     = 1'b1;
            w_load_val = r_pend;
        end else begin
            w_load = 1'b0;
        end
    end

    frame_builder #(.HEADER(HEADER)) u_frame (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_load),
        .i_value    (w_load_val),
`ifdef SEND_DATA_ALARM_EN
        .i_thr_high (thr_high),
        .i_thr_low  (thr_low),
`endif
        .i_byte_idx (r_byte_idx),
        .o_byte     (w_frame_byte)
    );

`ifndef SEND_DATA_ALARM_EN
    logic w_unused_thr;
    assign w_unused_thr = ^{thr_high, thr_low};
`endif

    // Control FSM, pending buffer and frame counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_armed      <= 1'b0;
            r_byte_idx   <= 2'd0;
            r_pend       <= 16'h0000;
            r_pend_valid <= 1'b0;
            r_tx_start   <= 1'b0;
            r_tx_data    <= 8'h00;
            r_overrun    <= 1'b0;
            r_frame_cnt  <= 8'h00;
        end else begin
            r_tx_start <= 1'b0;
            r_overrun  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (en_send && !r_armed) begin
                        r_armed <= 1'b1;
                        r_state <= ST_WAIT_SUM;
                    end
                end
                ST_WAIT_SUM: begin
                    if (sum_ready) begin
                        r_byte_idx <= 2'd0;
                        r_state    <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (!tx_busy) begin
                        r_tx_start <= 1'b1;
                        r_tx_data  <= w_frame_byte;
                        r_state    <= ST_WAIT_HI;
                    end
                end
                ST_WAIT_HI: begin
                    if (tx_busy) begin
                        r_state <= ST_WAIT_LO;
                    end
                end
                ST_WAIT_LO: begin
                    if (!tx_busy) begin
                        if (r_byte_idx != LAST_IDX) begin
                            r_byte_idx <= r_byte_idx + 2'd1;
                            r_state    <= ST_SEND;
                        end else begin
                            r_frame_cnt <= r_frame_cnt + 8'd1;
                            if (sum_ready || r_pend_valid) begin
                                r_byte_idx <= 2'd0;
                                r_state    <= ST_SEND;
                            end else begin
                                r_state <= ST_WAIT_SUM;
                            end
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase

            // A sum arriving mid-frame is buffered unless the frame ends this cycle.
            if (sum_ready && (r_state != ST_IDLE) && (r_state != ST_WAIT_SUM)) begin
                r_overrun <= r_pend_valid;
                if (w_frame_done) begin
                    r_pend_valid <= 1'b0;
                end else begin
                    r_pend       <= w_sum16;
                    r_pend_valid <= 1'b1;
                end
            end else if (w_frame_done) begin
                r_pend_valid <= 1'b0;
            end
        end
    end

    assign tx_start  = r_tx_start;
    assign tx_data   = r_tx_data;
    assign overrun   = r_overrun;
    assign frame_cnt = r_frame_cnt;

endmodule
